// File: rtl/ae_cmd_decoder.sv
// Host command stream decoder: parses framed 32-bit words from the
// write FIFO into register-write strobes and acquisition control.
module ae_cmd_decoder #(
    parameter int         TIMEOUT_CYC = 1024,
    parameter logic [7:0] MAGIC       = 8'hAE
) (
    input  logic        bus_clk,
    input  logic        RESET,
    input  logic        stream_open,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_dout,
    output logic        fifo_rd_en,
    output logic        reg_wr_en,
    output logic [7:0]  reg_addr,
    output logic [31:0] reg_wr_data,
    output logic        acq_enable,
    output logic        acq_start,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [15:0] err_count
);

    localparam int IW = $clog2(TIMEOUT_CYC);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);

    localparam logic [7:0] OP_WR    = 8'h01;
    localparam logic [7:0] OP_START = 8'h02;
    localparam logic [7:0] OP_STOP  = 8'h03;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_DATA = 2'd1,
        S_SKIP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    op_q, op_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    rem_q, rem_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          wr_en_q, wr_en_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic          acq_en_q, acq_en_d;
    logic          acq_st_q, acq_st_d;
    logic [15:0]   frame_q, frame_d;
    logic [15:0]   err_q, err_d;

    logic       pop;
    logic       err_inc;
    logic       frame_inc;
    logic       ctl_fire;
    logic [7:0] ctl_op;

    wire [7:0] hdr_magic = fifo_dout[31:24];
    wire [7:0] hdr_op    = fifo_dout[23:16];
    wire [7:0] hdr_addr  = fifo_dout[15:8];
    wire [7:0] hdr_cnt   = fifo_dout[7:0];
    wire       hdr_known = (hdr_op == OP_WR) || (hdr_op == OP_START) ||
                           (hdr_op == OP_STOP);

    always_ff @(posedge bus_clk) begin
        if (RESET) begin
            state_q   <= S_HDR;
            op_q      <= '0;
            addr_q    <= '0;
            rem_q     <= '0;
            idle_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            acq_en_q  <= 1'b0;
            acq_st_q  <= 1'b0;
            frame_q   <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            idle_q    <= idle_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            acq_en_q  <= acq_en_d;
            acq_st_q  <= acq_st_d;
            frame_q   <= frame_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        idle_d    = idle_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        acq_en_d  = acq_en_q;
        acq_st_d  = 1'b0;
        err_inc   = 1'b0;
        frame_inc = 1'b0;
        ctl_fire  = 1'b0;
        ctl_op    = op_q;

        if (!stream_open) begin
            // Host close drops any partial frame silently.
            state_d = S_HDR;
            idle_d  = '0;
        end else if (pop) begin
            idle_d = '0;
            unique case (state_q)
                S_HDR: begin
                    if (hdr_magic != MAGIC) begin
                        err_inc = 1'b1;
                    end else if (hdr_cnt == 8'd0) begin
                        if (hdr_known) begin
                            frame_inc = 1'b1;
                            ctl_fire  = 1'b1;
                            ctl_op    = hdr_op;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end else begin
                        op_d   = hdr_op;
                        addr_d = hdr_addr;
                        rem_d  = hdr_cnt;
                        if (hdr_known) begin
                            state_d = S_DATA;
                        end else begin
                            state_d = S_SKIP;
                            err_inc = 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (op_q == OP_WR) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = fifo_dout;
                    end
                    addr_d = addr_q + 8'd1;
                    rem_d  = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d   = S_HDR;
                        frame_inc = 1'b1;
                        ctl_fire  = 1'b1;
                    end
                end
                S_SKIP: begin
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = S_HDR;
                    end
                end
                default: state_d = S_HDR;
            endcase
        end else if (state_q != S_HDR && fifo_empty) begin
            if (idle_q == IDLE_LAST) begin
                state_d = S_HDR;
                idle_d  = '0;
                err_inc = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end

        if (ctl_fire && ctl_op == OP_START) begin
            acq_en_d = 1'b1;
            acq_st_d = 1'b1;
        end else if (ctl_fire && ctl_op == OP_STOP) begin
            acq_en_d = 1'b0;
        end

        frame_d = frame_q + {15'd0, frame_inc};
        err_d   = (err_inc && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    end

    always_comb begin
        fifo_rd_en  = !fifo_empty && stream_open && !RESET &&
                      (state_q == S_HDR || state_q == S_DATA ||
                       state_q == S_SKIP);
        pop         = fifo_rd_en;
        busy        = (state_q != S_HDR);
        reg_wr_en   = wr_en_q;
        reg_addr    = wr_addr_q;
        reg_wr_data = wr_data_q;
        acq_enable  = acq_en_q;
        acq_start   = acq_st_q;
        frame_count = frame_q;
        err_count   = err_q;
    end

endmodule

// File: tb/tb_ae_cmd_decoder.sv
// Bench for ae_cmd_decoder: FIFO model, write scoreboard, vector table
// and hand-written timeout / close / reset sequences.
module tb_ae_cmd_decoder;

    logic        bus_clk = 1'b0;
    logic        RESET = 1'b1;
    logic        stream_open = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_dout = '0;
    logic        fifo_rd_en;
    logic        reg_wr_en;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wr_data;
    logic        acq_enable;
    logic        acq_start;
    logic        busy;
    logic [15:0] frame_count;
    logic [15:0] err_count;

    always #5 bus_clk = ~bus_clk;

    ae_cmd_decoder #(.TIMEOUT_CYC(16), .MAGIC(8'hAE)) dut (
        .bus_clk(bus_clk),
        .RESET(RESET),
        .stream_open(stream_open),
        .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .reg_wr_en(reg_wr_en),
        .reg_addr(reg_addr),
        .reg_wr_data(reg_wr_data),
        .acq_enable(acq_enable),
        .acq_start(acq_start),
        .busy(busy),
        .frame_count(frame_count),
        .err_count(err_count)
    );

    typedef struct {
        string       name;
        int          nw;
        logic [31:0] w [5];
        int          ne;
        logic [7:0]  ea [3];
        logic [31:0] ed [3];
        logic [15:0] fc;
        logic [15:0] ec;
        logic        acq;
        int          st;
    } vec_t;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    vec_t        vt[$];
    wr_t         exp_wr[$];
    logic [31:0] fq[$];
    int          wr_cyc[$];
    int          nt = 0;
    int          nf = 0;
    int          cyc = 0;
    int          starts = 0;
    logic        rd_s = 1'b0;
    logic        busy_s = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nt++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic upd_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() != 0) ? fq[0] : 32'h0;
    endtask

    task automatic push(input logic [31:0] w);
        fq.push_back(w);
        upd_fifo();
    endtask

    task automatic expw(input logic [7:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_wr.push_back(e);
    endtask

    task automatic step();
        wr_t e;
        @(negedge bus_clk);
        rd_s   = fifo_rd_en;
        busy_s = busy;
        if (reg_wr_en) begin
            wr_cyc.push_back(cyc);
            if (exp_wr.size() == 0) begin
                nt++;
                nf++;
                $display("FAIL unexp_wr: got addr %h data %h, want none",
                         reg_addr, reg_wr_data);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_addr", {24'h0, reg_addr}, {24'h0, e.a});
                chk("wr_data", reg_wr_data, e.d);
            end
        end
        if (acq_start) starts++;
        @(posedge bus_clk);
        #1;
        cyc++;
        if (rd_s) begin
            if (fq.size() != 0) begin
                void'(fq.pop_front());
            end else begin
                nt++;
                nf++;
                $display("FAIL pop_empty: got pop, want none");
            end
        end
        upd_fifo();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        fq.delete();
        exp_wr.delete();
        upd_fifo();
        repeat (3) step();
        RESET  = 1'b0;
        starts = 0;
        wr_cyc.delete();
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((fq.size() != 0 || busy) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            nt++;
            nf++;
            $display("FAIL %s.drain: got still busy, want idle", nm);
        end
        repeat (2) step();
    endtask

    task automatic addv(input string nm, input int nw,
                        input logic [31:0] w0, w1, w2, w3, w4,
                        input int ne,
                        input logic [7:0] a0, a1, a2,
                        input logic [31:0] d0, d1, d2,
                        input logic [15:0] fc, ec,
                        input logic acq, input int st);
        vec_t v;
        v.name = nm;
        v.nw = nw;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
        v.ne = ne;
        v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2;
        v.ed[0] = d0; v.ed[1] = d1; v.ed[2] = d2;
        v.fc = fc;
        v.ec = ec;
        v.acq = acq;
        v.st = st;
        vt.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        addv("wr3", 4, 32'hAE01_1003, 32'h11, 32'h22, 32'h33, 0,
             3, 8'h10, 8'h11, 8'h12, 32'h11, 32'h22, 32'h33, 1, 0, 0, 0);
        addv("wrap", 4, 32'hAE01_FE03, 32'hA, 32'hB, 32'hC, 0,
             3, 8'hFE, 8'hFF, 8'h00, 32'hA, 32'hB, 32'hC, 1, 0, 0, 0);
        addv("resync", 2, 32'h1234_5678, 32'hAE02_0000, 0, 0, 0,
             0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
        addv("startstop", 3, 32'h1234_5678, 32'hAE02_0000, 32'hAE03_0000,
             0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1);
        addv("unkop", 5, 32'hAE7F_0002, 32'h1, 32'h2, 32'hAE01_2001,
             32'h55, 1, 8'h20, 0, 0, 32'h55, 0, 0, 1, 1, 0, 0);
        addv("startpl", 3, 32'hAE02_0002, 32'h9, 32'h8, 0, 0,
             0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        addv("badmagic", 1, 32'hAD01_0000, 0, 0, 0, 0,
             0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Reset state, with a word waiting that must not be popped.
        upd_fifo();
        repeat (2) step();
        push(32'hAE02_0000);
        step();
        chk("rst.rd_en", fifo_rd_en, 0);
        chk("rst.busy", busy, 0);
        chk("rst.wr_en", reg_wr_en, 0);
        chk("rst.addr", reg_addr, 0);
        chk("rst.data", reg_wr_data, 0);
        chk("rst.acq", acq_enable, 0);
        chk("rst.start", acq_start, 0);
        chk("rst.fc", frame_count, 0);
        chk("rst.ec", err_count, 0);

        foreach (vt[i]) begin
            do_reset();
            for (int j = 0; j < vt[i].nw; j++) push(vt[i].w[j]);
            for (int j = 0; j < vt[i].ne; j++) expw(vt[i].ea[j], vt[i].ed[j]);
            drain(vt[i].name);
            chk($sformatf("%s.fc", vt[i].name), frame_count, vt[i].fc);
            chk($sformatf("%s.ec", vt[i].name), err_count, vt[i].ec);
            chk($sformatf("%s.acq", vt[i].name), acq_enable, vt[i].acq);
            chk($sformatf("%s.starts", vt[i].name), starts, vt[i].st);
            chk($sformatf("%s.nwr", vt[i].name), wr_cyc.size(), vt[i].ne);
            chk($sformatf("%s.left", vt[i].name), exp_wr.size(), 0);
            chk($sformatf("%s.busy", vt[i].name), busy, 0);
            if (wr_cyc.size() >= 3)
                chk($sformatf("%s.b2b", vt[i].name),
                    wr_cyc[2] - wr_cyc[0], 2);
        end

        // Timeout: one payload word of four, then the FIFO runs dry.
        do_reset();
        push(32'hAE01_0004);
        push(32'h77);
        expw(8'h00, 32'h77);
        repeat (2) step();
        chk("to.pops", fq.size(), 0);
        n = 0;
        do begin
            step();
            if (busy_s) n++;
        end while (busy_s && n < 100);
        chk("to.cycles", n, 16);
        chk("to.ec", err_count, 1);
        chk("to.fc", frame_count, 0);
        chk("to.left", exp_wr.size(), 0);
        push(32'hAE02_0000);
        drain("to");
        chk("to.hdr_fc", frame_count, 1);
        chk("to.hdr_acq", acq_enable, 1);

        // Host close after 1 of 3 payload words.
        do_reset();
        push(32'hAE02_0000);
        push(32'hAE01_3003);
        push(32'hA1);
        expw(8'h30, 32'hA1);
        repeat (3) step();
        stream_open = 1'b0;
        push(32'hA2);
        push(32'hA3);
        repeat (4) step();
        chk("close.busy", busy, 0);
        chk("close.pops", fq.size(), 2);
        chk("close.ec", err_count, 0);
        chk("close.fc", frame_count, 1);
        chk("close.acq", acq_enable, 1);
        chk("close.left", exp_wr.size(), 0);
        fq.delete();
        upd_fifo();
        stream_open = 1'b1;

        // Reset after 1 of 3 payload words.
        do_reset();
        push(32'hDEAD_BEEF);
        push(32'hAE02_0000);
        push(32'hAE01_4003);
        push(32'hB1);
        expw(8'h40, 32'hB1);
        repeat (5) step();
        chk("rmid.pre_busy", busy, 1);
        push(32'hB2);
        RESET = 1'b1;
        step();
        chk("rmid.rd_en", rd_s, 0);
        chk("rmid.pops", fq.size(), 1);
        RESET = 1'b0;
        chk("rmid.fc", frame_count, 0);
        chk("rmid.ec", err_count, 0);
        chk("rmid.acq", acq_enable, 0);
        chk("rmid.busy", busy, 0);
        chk("rmid.addr", reg_addr, 0);
        chk("rmid.data", reg_wr_data, 0);
        fq.delete();
        push(32'hAE02_0000);
        drain("rmid");
        chk("rmid.hdr_fc", frame_count, 1);
        chk("rmid.hdr_acq", acq_enable, 1);
        chk("rmid.left", exp_wr.size(), 0);

        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule

// File: doc/ae_cmd_decoder.md
Name: ae_cmd_decoder

Overview:
- Consumes the host-to-FPGA command stream (/dev/xillybus_write_32), read from the FIFO on the bus_clk side.
- Parses framed 32-bit commands and turns them into register-write strobes and acquisition start/stop control for the AE acquisition path.
- Complements the FPGA-to-host sample stream: a write stream decoded into control, where the sample path is data encoded into a read stream.

Parameters:
- TIMEOUT_CYC, 1024, max bus_clk cycles FIFO may stay empty mid-frame before the frame is aborted (>=2)
- MAGIC, 8'hAE, required value of header bits [31:24]

Ports:
- bus_clk  input  1  sole clock
- RESET  input  1  synchronous, active-high reset
- stream_open  input  1  host device open (user_w_write_32_open)
- fifo_empty  input  1  command FIFO empty (first-word-fall-through)
- fifo_dout  input  32  FIFO head word; valid whenever fifo_empty=0
- fifo_rd_en  output  1  pop strobe; combinational, = accept condition below
- reg_wr_en  output  1  one-cycle register write strobe
- reg_addr  output  8  register address, valid with reg_wr_en
- reg_wr_data  output  32  register data, valid with reg_wr_en
- acq_enable  output  1  acquisition enable level
- acq_start  output  1  one-cycle pulse on START command
- busy  output  1  high when state != HDR
- frame_count  output  16  completed valid frames, wraps at 16'hFFFF->0
- err_count  output  16  error events, saturates at 16'hFFFF

Behaviour:
- Frame format: header {magic[31:24], opcode[23:16], addr[15:8], count[7:0]} followed by exactly count payload words.
- Opcodes:
  - 8'h01 WRITE_REG: payload word i is written to addr+i, 8-bit wrap (8'hFF -> 8'h00).
  - 8'h02 START: sets acq_enable=1 and pulses acq_start.
  - 8'h03 STOP: clears acq_enable.
  - For START and STOP, payload words are popped and discarded.
  - Any other opcode: error; payload is skipped.
- Accept condition: fifo_rd_en = !fifo_empty && stream_open && !RESET && state in {HDR, DATA, SKIP}. One word is consumed per cycle, so throughput is 1 word/clk.
- States:
  - HDR:
    - Word with bits[31:24] != MAGIC: popped, err_count+1, stay in HDR. This is the resync mechanism.
    - Valid header with count=0: frame completes in the pop cycle. START/STOP take effect registered next cycle. frame_count+1. Stay in HDR.
    - Valid header with count>0: latch opcode, addr and remaining=count. Go to DATA (opcode 01/02/03) or SKIP (unknown opcode, err_count+1 at the header).
  - DATA:
    - Each pop: WRITE_REG asserts reg_wr_en the next cycle, with reg_addr = current addr and reg_wr_data = word. Then addr+1 and remaining-1.
    - When remaining reaches 0: frame_count+1. START/STOP take effect at the pop of the last payload word (registered next cycle). Return to HDR.
  - SKIP: same as DATA but with no reg_wr_en and no frame_count increment.
- Latency: reg_wr_en, acq_start and acq_enable change exactly 1 cycle after the popping cycle. reg_wr_en is never asserted on two writes to the same cycle. Back-to-back payload words produce back-to-back strobes.
- Timeout:
  - Idle counter runs in DATA/SKIP while fifo_empty=1 and resets on every pop.
  - On reaching TIMEOUT_CYC: abort to HDR, err_count+1, no frame_count increment.
  - Register writes already issued are not rolled back.
- stream_open low:
  - No pops.
  - Any state returns to HDR next cycle without error.
  - acq_enable is held unchanged. Host close does not stop acquisition.
- Reset values: state=HDR, fifo_rd_en=0, reg_wr_en=0, reg_addr=0, reg_wr_data=0, acq_enable=0, acq_start=0, busy=0, frame_count=0, err_count=0, all internal counters 0.
- Reset mid-frame:
  - Discards the frame.
  - No pop occurs in the reset cycle.
  - Next word is parsed as a header.
- Simultaneous events:
  - Timeout and a pop in the same cycle: the pop wins and the counter clears.
  - err_count at 16'hFFFF stays at 16'hFFFF.
  - START while acq_enable=1: acq_start still pulses.

Test Plan:
- RESET 3 cycles, then header 32'hAE01_1003 + data 11,22,33 -> reg_wr_en pulses at addr 10,11,12 on consecutive cycles with data 11,22,33; frame_count=1, busy back low 1 cycle after last pop.
- Header 32'hAE01_FE03 + 3 words -> addresses FE, FF, 00 (wrap); err_count=0.
- Words 32'h1234_5678 then 32'hAE02_0000 -> err_count=1, then acq_start one-cycle pulse, acq_enable=1, frame_count=1; next 32'hAE03_0000 -> acq_enable=0, frame_count=2.
- Header 32'hAE7F_0002 + 2 words -> no reg_wr_en, err_count=1, frame_count=0; following valid WRITE_REG executes normally.
- TIMEOUT_CYC=16: header 32'hAE01_0004 + 1 word, FIFO then empty -> 1 reg_wr_en, abort after 16 empty cycles, err_count=1; next word is parsed as a header.
- Mid-frame stream_open deasserted (and separately RESET asserted) after 1 of 3 payload words -> state returns to HDR, no further pops or writes; close case leaves err_count unchanged; RESET case clears all counters and outputs.
